// File: rtl/pim_pkg.sv
// -----------------------------------------------------------------------------
// pim_pkg
// Shared definitions for the PIM partial-sum accumulation stage: default
// datapath widths, frame-level FSM state encoding and the requantisation
// helper that turns an accumulated sum into a 6-bit activation.
// No ports (package).
// -----------------------------------------------------------------------------
package pim_pkg;

    localparam int PSUM_W     = 18;
    localparam int OUT_W      = 6;
    localparam int ADDR_W     = 5;
    localparam int ACC_W      = 24;
    localparam int ADDR_NUM   = 32;
    localparam int SHIFT      = 2;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } frame_state_e;

    // Right-shift the accumulated sum, then clamp to the largest OUT_W value.
    function automatic logic [OUT_W-1:0] requant_clamp(input logic [ACC_W-1:0] sum,
                                                       input int unsigned      shift);
        logic [ACC_W-1:0] q;
        q = sum >> shift;
        if (q > ACC_W'((1 << OUT_W) - 1)) begin
            return '1;
        end
        return q[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/pim_psum_accum_if.sv
// -----------------------------------------------------------------------------
// pim_psum_accum_if
// Bundles the partial-sum input beat, the requantised output handshake and the
// frame status flags of pim_psum_accum.
//   master : producer/consumer side (drives psum beat and out_ready)
//   slave  : the accumulator (drives psum_ready, out_*, frame_done, err)
// -----------------------------------------------------------------------------
interface pim_psum_accum_if #(
    parameter int ADDR_W = pim_pkg::ADDR_W,
    parameter int PSUM_W = pim_pkg::PSUM_W,
    parameter int OUT_W  = pim_pkg::OUT_W
) ();

    logic [PSUM_W-1:0] psum_in;
    logic [ADDR_W-1:0] psum_addr;
    logic              psum_first;
    logic              psum_last;
    logic              psum_valid;
    logic              psum_ready;

    logic [OUT_W-1:0]  out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_valid;
    logic              out_ready;

    logic              frame_done;
    logic              err;

    modport master (
        output psum_in, psum_addr, psum_first, psum_last, psum_valid, out_ready,
        input  psum_ready, out_data, out_addr, out_valid, frame_done, err
    );

    modport slave (
        input  psum_in, psum_addr, psum_first, psum_last, psum_valid, out_ready,
        output psum_ready, out_data, out_addr, out_valid, frame_done, err
    );

endinterface

// File: rtl/pim_out_fifo.sv
// -----------------------------------------------------------------------------
// pim_out_fifo
// First-word-fall-through FIFO. The head entry is visible on head_o whenever
// valid_o is high; when empty, head_o holds the last popped entry.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push_i         write push_data_i (caller guarantees space)
//   push_data_i    entry to write
//   pop_i          consume head entry (ignored when empty)
//   head_o         head entry / last popped entry when empty
//   valid_o        FIFO non-empty
//   count_o        number of stored entries
// -----------------------------------------------------------------------------
module pim_out_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] hold_q;

    logic push_ok;
    logic pop_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != CNT_W'(DEPTH)) || pop_ok);

    // NOTE: storage is not reset; an entry is only visible once count_q says
    // it was written, so clearing it would cost reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: non-blocking assignments in every clocked block, so all registers
    // sample the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                hold_q   <= mem_q[rd_ptr_q];
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o = (count_q != '0);
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : hold_q;
    assign count_o = count_q;

endmodule

// File: rtl/pim_psum_accum.sv
// -----------------------------------------------------------------------------
// pim_psum_accum
// Accumulates 18-bit partial sums from the PIM convolution unit across input
// channel passes (one saturating accumulator per PIM address). On the last
// pass the total is shifted and clamped to a 6-bit activation, staged for one
// cycle and pushed into a small FWFT output FIFO.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        pim_psum_accum_if.slave:
//                psum_in/addr/first/last/valid -> psum_ready   input beat
//                out_data/addr/valid           <- out_ready    result stream
//                frame_done  one-cycle pulse after ADDR_NUM pops
//                err         sticky: continuation beat to unwritten address
// -----------------------------------------------------------------------------
module pim_psum_accum
    import pim_pkg::*;
#(
    parameter int ADDR_NUM   = pim_pkg::ADDR_NUM,
    parameter int ADDR_W     = pim_pkg::ADDR_W,
    parameter int PSUM_W     = pim_pkg::PSUM_W,
    parameter int ACC_W      = pim_pkg::ACC_W,
    parameter int OUT_W      = pim_pkg::OUT_W,
    parameter int SHIFT      = pim_pkg::SHIFT,
    parameter int FIFO_DEPTH = pim_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    pim_psum_accum_if.slave   bus
);

    localparam int SUM_W  = ACC_W + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int FR_W   = $clog2(ADDR_NUM);
    localparam int ENTRY_W = ADDR_W + OUT_W;

    // Accumulator array and per-address "has a partial sum" flags.
    logic [ACC_W-1:0]    acc_q [ADDR_NUM];
    logic [ADDR_NUM-1:0] written_q;

    // One-entry stage between the requantiser and the FIFO.
    logic                stage_valid_q;
    logic [ENTRY_W-1:0]  stage_entry_q;

    frame_state_e        state_q;
    logic [FR_W-1:0]     emit_cnt_q;
    logic [FR_W-1:0]     pop_cnt_q;
    logic                frame_done_q;
    logic                err_q;

    logic                accept;
    logic                emit;
    logic                pop;
    logic                last_result;
    logic [ACC_W-1:0]    old_val_d;
    logic [SUM_W-1:0]    sum_wide_d;
    logic [ACC_W-1:0]    sum_d;
    logic [OUT_W-1:0]    q_d;

    logic [ENTRY_W-1:0]  fifo_head;
    logic                fifo_valid;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W-1:0]    occupancy;

    assign accept = bus.psum_valid && bus.psum_ready;
    assign emit   = accept && bus.psum_last;
    assign pop    = fifo_valid && bus.out_ready;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        old_val_d  = '0;
        sum_wide_d = '0;
        sum_d      = '0;
        q_d        = '0;
        // An unwritten address contributes 0 even on a continuation beat.
        if (!bus.psum_first && written_q[bus.psum_addr]) begin
            old_val_d = acc_q[bus.psum_addr];
        end
        sum_wide_d = {1'b0, old_val_d} + SUM_W'(bus.psum_in);
        sum_d      = sum_wide_d[ACC_W] ? '1 : sum_wide_d[ACC_W-1:0];
        q_d        = requant_clamp(sum_d, SHIFT);
    end

    // The stage entry is counted as occupied so that a push can never find
    // the FIFO full; a pop in the same cycle is deliberately not credited.
    assign occupancy      = fifo_count + CNT_W'(stage_valid_q);
    assign bus.psum_ready = (occupancy < CNT_W'(FIFO_DEPTH)) && (state_q != ST_DRAIN);

    assign last_result = (emit_cnt_q == FR_W'(ADDR_NUM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ADDR_NUM; i++) begin
                acc_q[i] <= '0;
            end
            written_q     <= '0;
            stage_valid_q <= 1'b0;
            stage_entry_q <= '0;
            state_q       <= ST_IDLE;
            emit_cnt_q    <= '0;
            pop_cnt_q     <= '0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            // Accumulate, or clear the entry once its result is emitted.
            if (accept) begin
                if (bus.psum_last) begin
                    acc_q[bus.psum_addr]     <= '0;
                    written_q[bus.psum_addr] <= 1'b0;
                end else begin
                    acc_q[bus.psum_addr]     <= sum_d;
                    written_q[bus.psum_addr] <= 1'b1;
                end
                if (!bus.psum_first && !written_q[bus.psum_addr]) begin
                    err_q <= 1'b1;
                end
            end

            // Stage always drains into the FIFO on the following edge.
            stage_valid_q <= emit;
            if (emit) begin
                stage_entry_q <= {bus.psum_addr, q_d};
            end

            if (emit) begin
                emit_cnt_q <= last_result ? '0 : emit_cnt_q + 1'b1;
            end

            if (pop) begin
                pop_cnt_q <= (pop_cnt_q == FR_W'(ADDR_NUM - 1)) ? '0 : pop_cnt_q + 1'b1;
            end
            frame_done_q <= pop && (pop_cnt_q == FR_W'(ADDR_NUM - 1));

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (emit && last_result) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (frame_done_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    pim_out_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (stage_valid_q),
        .push_data_i (stage_entry_q),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .valid_o     (fifo_valid),
        .count_o     (fifo_count)
    );

    assign bus.out_valid  = fifo_valid;
    assign bus.out_addr   = fifo_head[ENTRY_W-1:OUT_W];
    assign bus.out_data   = fifo_head[OUT_W-1:0];
    assign bus.frame_done = frame_done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_pim_psum_accum.sv
// -----------------------------------------------------------------------------
// tb_pim_psum_accum
// Directed testbench for pim_psum_accum: single- and multi-pass accumulation,
// clamping, the unwritten-address error, FIFO backpressure and ordering, a full
// 32-address frame with frame_done, and reset in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_pim_psum_accum;
    import pim_pkg::*;

    logic clk;
    logic rst;

    int   pass_cnt;
    int   total_cnt;
    int   fail_cnt;

    pim_psum_accum_if bus ();

    pim_psum_accum dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int addr, input int psum, input logic first, input logic last);
        bus.psum_valid = 1'b1;
        bus.psum_addr  = addr[ADDR_W-1:0];
        bus.psum_in    = psum[PSUM_W-1:0];
        bus.psum_first = first;
        bus.psum_last  = last;
    endtask

    task automatic idle();
        bus.psum_valid = 1'b0;
        bus.psum_first = 1'b0;
        bus.psum_last  = 1'b0;
        bus.psum_in    = '0;
        bus.psum_addr  = '0;
    endtask

    initial begin
        int pop_idx;
        int fd_cnt;
        int miss;
        pass_cnt  = 0;
        total_cnt = 0;
        fail_cnt  = 0;
        rst       = 1'b1;
        bus.out_ready = 1'b0;
        idle();
        tick();
        tick();

        // Reset state
        check("rst_psum_ready", bus.psum_ready, 1);
        check("rst_out_valid",  bus.out_valid,  0);
        check("rst_out_data",   bus.out_data,   0);
        check("rst_out_addr",   bus.out_addr,   0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_err",        bus.err,        0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();

        // Two passes on addr 3: (40+20)>>2 = 15, visible one cycle after accept
        beat(3, 40, 1'b1, 1'b0); tick();
        beat(3, 20, 1'b0, 1'b1); tick();
        idle();
        check("t1_not_yet_valid", bus.out_valid, 0);
        tick();
        check("t1_valid", bus.out_valid, 1);
        check("t1_addr",  bus.out_addr,  3);
        check("t1_data",  bus.out_data,  15);
        tick();
        check("t1_popped",    bus.out_valid, 0);
        check("t1_hold_data", bus.out_data,  15);

        // Three passes: 100+200+50 = 350, >>2 = 87, clamped to 63
        beat(3, 100, 1'b1, 1'b0); tick();
        beat(3, 200, 1'b0, 1'b0); tick();
        beat(3, 50,  1'b0, 1'b1); tick();
        idle(); tick();
        check("t2_addr", bus.out_addr, 3);
        check("t2_data", bus.out_data, 63);
        tick();

        // Single-pass maximum input clamps to 63, no error
        beat(7, 262143, 1'b1, 1'b1); tick();
        idle(); tick();
        check("t3_addr", bus.out_addr, 7);
        check("t3_data", bus.out_data, 63);
        check("t3_err",  bus.err,      0);
        tick();

        // Continuation beat to never-written addr 9: 8>>2 = 2, err set
        beat(9, 8, 1'b0, 1'b1); tick();
        check("t4_err_set", bus.err, 1);
        idle(); tick();
        check("t4_addr", bus.out_addr, 9);
        check("t4_data", bus.out_data, 2);
        tick();
        check("t4_err_sticky", bus.err, 1);

        // Backpressure: four results to addrs 0..3 with out_ready low
        bus.out_ready = 1'b0;
        for (int a = 0; a < 4; a++) begin
            check("t5_ready_before", bus.psum_ready, 1);
            beat(a, 4 * (a + 1), 1'b1, 1'b1);
            tick();
        end
        check("t5_ready_dropped", bus.psum_ready, 0);
        idle(); tick();
        check("t5_ready_still_low", bus.psum_ready, 0);
        bus.out_ready = 1'b1;
        for (int a = 0; a < 4; a++) begin
            check("t5_pop_addr", bus.out_addr, a);
            check("t5_pop_data", bus.out_data, a + 1);
            tick();
        end
        check("t5_empty",     bus.out_valid,  0);
        check("t5_ready_back", bus.psum_ready, 1);
        check("t5_err_sticky", bus.err,       1);

        // Fresh frame
        rst = 1'b1; tick();
        check("rst2_err",      bus.err,       0);
        check("rst2_out_data", bus.out_data,  0);
        rst = 1'b0; tick();

        // Full frame: 32 single-pass beats, data = addr
        pop_idx = 0;
        fd_cnt  = 0;
        miss    = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (cyc < 32) begin
                if (!bus.psum_ready) miss++;
                beat(cyc, 4 * cyc, 1'b1, 1'b1);
            end else begin
                idle();
            end
            tick();
            if (bus.out_valid) begin
                check("t6_pop_entry", {20'd0, bus.out_addr, bus.out_data},
                      32'((pop_idx << 6) | pop_idx));
                pop_idx++;
            end
            if (bus.frame_done) fd_cnt++;
        end
        check("t6_no_stall",    miss,           0);
        check("t6_pop_count",   pop_idx,        32);
        check("t6_frame_done",  fd_cnt,         1);
        check("t6_ready_idle",  bus.psum_ready, 1);
        check("t6_state_idle",  dut.state_q,    ST_IDLE);

        // Reset in the middle of a frame
        bus.out_ready = 1'b0;
        beat(5, 100, 1'b1, 1'b0); tick();
        beat(6, 40,  1'b1, 1'b1); tick();
        idle(); tick();
        check("t7_pre_valid", bus.out_valid, 1);
        rst = 1'b1; tick();
        check("t7_valid_cleared", bus.out_valid,  0);
        check("t7_ready",         bus.psum_ready, 1);
        check("t7_state",         dut.state_q,    ST_IDLE);
        rst = 1'b0; tick(); tick();
        check("t7_no_escape", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        // Addr 5 partial sum was discarded: continuation sees 0 and flags err
        beat(5, 8, 1'b0, 1'b1); tick();
        check("t7_err", bus.err, 1);
        idle(); tick();
        check("t7_addr", bus.out_addr, 5);
        check("t7_data", bus.out_data, 2);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pim_psum_accum.md
Name: pim_psum_accum

Overview:
- Downstream stage of the 6-bit PIM convolution unit. Consumes its 18-bit per-address partial sums.
- Accumulates partial sums across successive input-channel passes, one accumulator per PIM address.
- On the last pass, requantizes the total to a 6-bit activation (shift, clamp) for the next layer.
- Buffers results in a small output FIFO with a valid/ready handshake.

Parameters:
- ADDR_NUM, 32, number of PIM addresses / accumulator entries
- ADDR_W, 5, address width; must satisfy ADDR_NUM <= 2**ADDR_W
- PSUM_W, 18, partial-sum input width
- ACC_W, 24, accumulator width
- OUT_W, 6, requantized output width
- SHIFT, 2, right-shift applied before clamping
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >= 2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- psum_in  in  PSUM_W  unsigned partial sum from PIM conv
- psum_addr  in  ADDR_W  PIM address the sum belongs to
- psum_first  in  1  first channel pass: overwrite accumulator
- psum_last  in  1  last channel pass: emit result
- psum_valid  in  1  beat valid
- psum_ready  out  1  beat accepted when valid&&ready
- out_data  out  OUT_W  requantized activation
- out_addr  out  ADDR_W  address of out_data
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pop
- frame_done  out  1  one-cycle pulse when ADDR_NUM results have been popped
- err  out  1  sticky protocol error flag

Behaviour:
- Reset: every acc entry=0, every written flag=0, stage register empty, FIFO empty, out_valid=0, out_data=0, out_addr=0, frame_done=0, err=0, pop counter=0, psum_ready=1.
- Reset mid-operation discards all partial sums and buffered results. No output escapes after the reset edge.
- Accept occurs when psum_valid&&psum_ready. Dropping valid without acceptance is legal; the beat is simply not taken.
- Sum formation:
  - sum = (psum_first ? 0 : acc[addr]) + zero-extended psum_in.
  - sum saturates at 2**ACC_W-1; no wrap.
  - acc[addr] <= sum and written[addr] <= 1 on the accept edge.
- Back-to-back beats to the same address must accumulate correctly. Accumulators are flops with a combinational read, so there is no hazard.
- psum_first&&psum_last together: a single-pass result.
- Accept with psum_first=0 and written[addr]=0: old value is treated as 0, err set (sticky until rst).
- Accept with psum_last=1:
  - q = sum>>SHIFT, clamped to 2**OUT_W-1.
  - {q,addr} loads the stage register on the accept edge.
  - Stage pushes into the FIFO on the next edge, so out_valid can rise 1 cycle after the accept edge when the FIFO was empty.
  - After an emit, written[addr] is cleared and acc[addr] is reset to 0.
- psum_ready = (fifo_count + stage_valid) < FIFO_DEPTH. This is conservative: a same-cycle pop earns no credit, so the FIFO can never overflow.
- FIFO is first-word-fall-through. out_data/out_addr show the head entry; they hold their last value when empty.
- Pop occurs when out_valid&&out_ready. Simultaneous push and pop is allowed; count is unchanged.
- out_ready while empty has no effect.
- Pop counter wraps to 0 at ADDR_NUM. frame_done pulses on the cycle after the ADDR_NUM-th pop.
- Control FSM (frame level):
  - IDLE -> ACCUM on first accept.
  - ACCUM -> DRAIN when the emitted-result count reaches ADDR_NUM.
  - DRAIN -> IDLE on frame_done. psum_ready is held 0 while in DRAIN.

Decomposition:
- Shared package pim_pkg holds PSUM_W=18, OUT_W=6, ADDR_W=5 and a requant-clamp function.
- One sub-module, pim_out_fifo: parameterised FWFT FIFO carrying {addr,data}, with a count output.

Test Plan:
- Addr 3 gets first 40, then last 20 -> out_addr=3, out_data=15 one cycle after the last accept edge.
- Addr 3 gets first 100, mid 200, last 50 (sum 350) -> out_data=63 (87 clamped).
- Addr 7 gets a single beat with first=last=1, psum_in=2**18-1 -> out_data=63; err stays 0.
- Addr 9 gets first=0 on a never-written address, psum_in=8, last=1 -> out_data=2, err=1 and stays 1.
- out_ready=0 with 4 last beats to addrs 0..3 -> psum_ready drops after the 4th accept. Raising out_ready pops 0,1,2,3 in order.
- 32 single-pass beats, addrs 0..31, out_ready=1 -> 32 pops and one frame_done pulse; FSM returns to IDLE. Asserting rst mid-frame clears out_valid on the next edge.
